// File: rtl/dq_cal_pkg.sv
// Shared types and constants for the DQ read-capture tap calibration.
// Training pattern and FSM encoding used by dq_tap_cal and its sampler.
package dq_cal_pkg;

  localparam logic PAT_Q1 = 1'b1;
  localparam logic PAT_Q2 = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ZERO,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_PARKRST,
    ST_PARKINC,
    ST_FAILRST,
    ST_FIN
  } calState_t;

  function automatic logic patMatch(
    input logic q1,
    input logic q2,
    input logic inv
  );
    if (inv) return (q1 == ~PAT_Q1) && (q2 == ~PAT_Q2);
    return (q1 == PAT_Q1) && (q2 == PAT_Q2);
  endfunction

endpackage

// File: rtl/dq_tap_cal_if.sv
// IOB-side bundle for one DQ lane: ISERDES data in, IDELAY control out.
// master = calibration logic, slave = IOB / IDELAY.
interface dq_tap_cal_if;

  logic IserdesQ1;
  logic IserdesQ2;
  logic DlyInc;
  logic DlyReset;

  modport master (
    input  IserdesQ1,
    input  IserdesQ2,
    output DlyInc,
    output DlyReset
  );

  modport slave (
    output IserdesQ1,
    output IserdesQ2,
    input  DlyInc,
    input  DlyReset
  );

endinterface

// File: rtl/dq_cal_sampler.sv
// Per-tap settle timer and consecutive-match counter.
// Emits a single pass or fail strobe for each tap under test.
module dq_cal_sampler #(
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLES    = 16
) (
  input  logic MCLK90,
  input  logic Reset_n,
  input  logic settleEn,
  input  logic sampleEn,
  input  logic match,
  output logic settleDone,
  output logic passStb,
  output logic failStb
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(SAMPLES + 1);

  logic [SW-1:0] settleCnt;
  logic [MW-1:0] matchCnt;

  // settle timer runs only while the FSM waits after a tap change
  always_ff @(posedge MCLK90) begin
    if (!Reset_n)      settleCnt <= '0;
    else if (!settleEn) settleCnt <= '0;
    else               settleCnt <= settleCnt + SW'(1);
  end

  // any mismatch restarts the run of consecutive good samples
  always_ff @(posedge MCLK90) begin
    if (!Reset_n)               matchCnt <= '0;
    else if (!sampleEn || !match) matchCnt <= '0;
    else                        matchCnt <= matchCnt + MW'(1);
  end

  assign settleDone = settleEn &&
    (settleCnt == SW'(SETTLE_CYC - 1));
  assign passStb = sampleEn && match &&
    (matchCnt == MW'(SAMPLES - 1));
  assign failStb = sampleEn && !match;

endmodule

// File: rtl/dq_tap_cal.sv
// Read-capture tap calibration for one DQ lane: sweep IDELAY, centre on eye.
// Optional DQ_CAL_SWAP_DETECT_EN accepts inverted Q1/Q2 phase, adds Swapped.
module dq_tap_cal
  import dq_cal_pkg::*;
#(
  parameter int MAX_TAP    = 63,
  parameter int TAPW       = 6,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLES    = 16
) (
  input  logic            MCLK90,
  input  logic            Reset_n,
  input  logic            Start,
  dq_tap_cal_if.master    iob,
  output logic            Busy,
  output logic            Done,
  output logic            Fail,
  output logic [TAPW-1:0] TapValue,
  output logic [TAPW:0]   EyeWidth
`ifdef DQ_CAL_SWAP_DETECT_EN
  ,
  output logic            Swapped
`endif
);

  calState_t state, nxt;

  logic dlyInc, dlyRst;
  logic match;
  logic settleDone, passStb, failStb;

  logic            tapPass;
  logic            leftVld;
  logic            finOk;
  logic [TAPW-1:0] leftR;
  logic [TAPW-1:0] centreR;
  logic [TAPW-1:0] parkCnt;

  logic            atMax, closed, anyPass;
  logic [TAPW-1:0] leftEff, rightEff;
  logic [TAPW-1:0] spanW, centreW;
  logic [TAPW:0]   eyeW;

`ifdef DQ_CAL_SWAP_DETECT_EN
  logic lockVld, lockInv, tapInv, phaseInv;

  // unlocked: follow the phase seen at the end of settle
  always_comb begin
    phaseInv = lockVld ? lockInv : tapInv;
    match = patMatch(iob.IserdesQ1, iob.IserdesQ2, phaseInv);
  end
`else
  // only the nominal training phase counts
  always_comb begin
    match = patMatch(iob.IserdesQ1, iob.IserdesQ2, 1'b0);
  end
`endif

  dq_cal_sampler #(
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLES    (SAMPLES)
  ) sampler (
    .MCLK90     (MCLK90),
    .Reset_n    (Reset_n),
    .settleEn   (state == ST_SETTLE),
    .sampleEn   (state == ST_SAMPLE),
    .match      (match),
    .settleDone (settleDone),
    .passStb    (passStb),
    .failStb    (failStb)
  );

  // window bookkeeping evaluated once per tap
  always_comb begin
    atMax    = (TapValue == TAPW'(MAX_TAP));
    closed   = (leftVld && !tapPass) || atMax;
    anyPass  = leftVld || tapPass;
    leftEff  = leftVld ? leftR : TapValue;
    rightEff = tapPass ? TapValue : TapValue - TAPW'(1);
    spanW    = rightEff - leftEff;
    centreW  = leftEff + (spanW >> 1);
    eyeW     = {1'b0, spanW} + (TAPW + 1)'(1);
  end

  // FSM state register
  always_ff @(posedge MCLK90) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // next state and IDELAY strobes
  always_comb begin
    nxt    = state;
    dlyInc = 1'b0;
    dlyRst = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Start) nxt = ST_ZERO;
      end
      ST_ZERO: begin
        dlyRst = 1'b1;
        nxt    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settleDone) nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (passStb || failStb) nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (!closed)      nxt = ST_STEP;
        else if (anyPass) nxt = ST_PARKRST;
        else              nxt = ST_FAILRST;
      end
      ST_STEP: begin
        dlyInc = 1'b1;
        nxt    = ST_SETTLE;
      end
      ST_PARKRST: begin
        dlyRst = 1'b1;
        nxt    = (centreR == '0) ? ST_FIN : ST_PARKINC;
      end
      ST_PARKINC: begin
        dlyInc = 1'b1;
        if (parkCnt == TAPW'(1)) nxt = ST_FIN;
      end
      ST_FAILRST: begin
        dlyRst = 1'b1;
        nxt    = ST_FIN;
      end
      ST_FIN: begin
        nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign iob.DlyInc   = dlyInc;
  assign iob.DlyReset = dlyRst;
  assign Busy         = (state != ST_IDLE);

  // tap tracking, window registers and sticky result flags
  always_ff @(posedge MCLK90) begin
    if (!Reset_n) begin
      TapValue <= '0;
      EyeWidth <= '0;
      Done     <= 1'b0;
      Fail     <= 1'b0;
      tapPass  <= 1'b0;
      leftVld  <= 1'b0;
      leftR    <= '0;
      centreR  <= '0;
      parkCnt  <= '0;
      finOk    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (Start) begin
            Done     <= 1'b0;
            Fail     <= 1'b0;
            EyeWidth <= '0;
            leftVld  <= 1'b0;
          end
        end
        ST_ZERO: TapValue <= '0;
        ST_SAMPLE: begin
          if (passStb)      tapPass <= 1'b1;
          else if (failStb) tapPass <= 1'b0;
        end
        ST_EVAL: begin
          if (tapPass && !leftVld) begin
            leftVld <= 1'b1;
            leftR   <= TapValue;
          end
          if (closed) finOk <= anyPass;
          if (closed && anyPass) begin
            centreR  <= centreW;
            EyeWidth <= eyeW;
          end
        end
        ST_STEP: TapValue <= TapValue + TAPW'(1);
        ST_PARKRST: begin
          TapValue <= '0;
          parkCnt  <= centreR;
        end
        ST_PARKINC: begin
          TapValue <= TapValue + TAPW'(1);
          parkCnt  <= parkCnt - TAPW'(1);
        end
        ST_FAILRST: begin
          TapValue <= '0;
          EyeWidth <= '0;
        end
        ST_FIN: begin
          Done <= finOk;
          Fail <= !finOk;
        end
        default: ;
      endcase
    end
  end

`ifdef DQ_CAL_SWAP_DETECT_EN
  // lock the phase on the first passing tap of a run
  always_ff @(posedge MCLK90) begin
    if (!Reset_n) begin
      lockVld <= 1'b0;
      lockInv <= 1'b0;
      tapInv  <= 1'b0;
      Swapped <= 1'b0;
    end else begin
      if (state == ST_IDLE && Start) begin
        lockVld <= 1'b0;
        lockInv <= 1'b0;
        Swapped <= 1'b0;
      end
      if (state == ST_SETTLE)
        tapInv <= patMatch(iob.IserdesQ1, iob.IserdesQ2, 1'b1);
      if (state == ST_EVAL && tapPass && !lockVld) begin
        lockVld <= 1'b1;
        lockInv <= tapInv;
      end
      if (state == ST_FIN) Swapped <= finOk && lockInv;
    end
  end
`endif

endmodule

// File: tb/tb_dq_tap_cal.sv
// Directed bench for dq_tap_cal with a behavioural IDELAY tap model.
// Q1/Q2 are driven from the modelled tap and a configurable pass window.
module tb_dq_tap_cal;

  logic       MCLK90;
  logic       Reset_n;
  logic       Start;
  logic       Busy, Done, Fail;
  logic [5:0] TapValue;
  logic [6:0] EyeWidth;
`ifdef DQ_CAL_SWAP_DETECT_EN
  logic       Swapped;
`endif

  dq_tap_cal_if dqIf ();

  dq_tap_cal dut (
    .MCLK90   (MCLK90),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .iob      (dqIf.master),
    .Busy     (Busy),
    .Done     (Done),
    .Fail     (Fail),
    .TapValue (TapValue),
    .EyeWidth (EyeWidth)
`ifdef DQ_CAL_SWAP_DETECT_EN
    ,
    .Swapped  (Swapped)
`endif
  );

  int checks = 0;
  int errors = 0;

  int modelTap = 0;
  int dwell    = 0;
  int incCnt   = 0;
  int rstCnt   = 0;
  int bothCnt  = 0;

  int winLo     = 99;
  int winHi     = -1;
  bit winInv    = 0;
  bit glitchOn  = 0;
  int glitchTap = 12;

  logic q1, q2;

  initial MCLK90 = 1'b0;
  always #5 MCLK90 = ~MCLK90;

  // IDELAY model: reset wins, otherwise one tap per DlyInc
  always @(posedge MCLK90) begin
    if (dqIf.DlyReset && dqIf.DlyInc) bothCnt <= bothCnt + 1;
    if (dqIf.DlyReset) begin
      modelTap <= 0;
      rstCnt   <= rstCnt + 1;
      dwell    <= 0;
    end else if (dqIf.DlyInc) begin
      modelTap <= modelTap + 1;
      incCnt   <= incCnt + 1;
      dwell    <= 0;
    end else begin
      dwell <= dwell + 1;
    end
  end

  always_comb begin
    q1 = 1'b0;
    q2 = 1'b0;
    if (modelTap >= winLo && modelTap <= winHi &&
        !(glitchOn && modelTap == glitchTap && dwell == 12)) begin
      q1 = !winInv;
      q2 = winInv;
    end
  end

  assign dqIf.IserdesQ1 = q1;
  assign dqIf.IserdesQ2 = q2;

  task automatic checkVal(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic runCal(
    input string tag,
    input int    lo,
    input int    hi,
    input bit    inv,
    input bit    glitch,
    input bit    hold,
    input int    expDone,
    input int    expTap,
    input int    expEw,
    input int    expInc
  );
    int incBase;
    int rstBase;
    bit fin;
    winLo    = lo;
    winHi    = hi;
    winInv   = inv;
    glitchOn = glitch;
    @(negedge MCLK90);
    incBase = incCnt;
    rstBase = rstCnt;
    Start = 1'b1;
    @(negedge MCLK90);
    Start = 1'b0;
    checkVal({tag, ".zero"},
      {29'd0, Busy, dqIf.DlyReset, dqIf.DlyInc}, 32'd6);
    fin = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge MCLK90);
      if (!Busy) begin
        fin = 1;
        break;
      end
      Start = hold;
    end
    Start = 1'b0;
    checkVal({tag, ".fin"}, 32'(fin), 32'd1);
    checkVal({tag, ".done"}, 32'(Done), 32'(expDone));
    checkVal({tag, ".fail"}, 32'(Fail), 32'(expDone == 0));
    checkVal({tag, ".tap"}, 32'(TapValue), 32'(expTap));
    checkVal({tag, ".ew"}, 32'(EyeWidth), 32'(expEw));
    checkVal({tag, ".inc"}, 32'(incCnt - incBase), 32'(expInc));
    checkVal({tag, ".rst"}, 32'(rstCnt - rstBase), 32'd2);
    checkVal({tag, ".idelay"}, 32'(modelTap), 32'(expTap));
`ifdef DQ_CAL_SWAP_DETECT_EN
    checkVal({tag, ".swp"}, 32'(Swapped), 32'(inv && expDone != 0));
`endif
    if (hold) begin
      repeat (2) @(negedge MCLK90);
      checkVal({tag, ".norestart"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    bit hit;
    Reset_n = 1'b0;
    Start   = 1'b0;
    repeat (3) @(negedge MCLK90);
    checkVal("rst.busy", 32'(Busy), 32'd0);
    checkVal("rst.done", 32'(Done), 32'd0);
    checkVal("rst.fail", 32'(Fail), 32'd0);
    checkVal("rst.tap", 32'(TapValue), 32'd0);
    checkVal("rst.ew", 32'(EyeWidth), 32'd0);
    checkVal("rst.strobes",
      {30'd0, dqIf.DlyReset, dqIf.DlyInc}, 32'd0);
`ifdef DQ_CAL_SWAP_DETECT_EN
    checkVal("rst.swp", 32'(Swapped), 32'd0);
`endif
    Reset_n = 1'b1;

    runCal("w10_30", 10, 30, 0, 0, 0, 1, 20, 21, 51);
    runCal("nopass", 99, -1, 0, 0, 0, 0, 0, 0, 63);
    runCal("w50_63", 50, 63, 0, 0, 0, 1, 56, 14, 119);
    runCal("w0", 0, 0, 0, 0, 0, 1, 0, 1, 1);
    runCal("glitch", 10, 30, 0, 1, 0, 1, 10, 2, 22);
    runCal("hold", 20, 40, 0, 0, 1, 1, 30, 21, 71);

    // abort mid-scan with reset, then rescan from tap 0
    winLo    = 10;
    winHi    = 30;
    winInv   = 0;
    glitchOn = 0;
    @(negedge MCLK90);
    Start = 1'b1;
    @(negedge MCLK90);
    Start = 1'b0;
    hit = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge MCLK90);
      if (TapValue == 6'd25) begin
        hit = 1;
        break;
      end
    end
    checkVal("abort.reach25", 32'(hit), 32'd1);
    Reset_n = 1'b0;
    @(negedge MCLK90);
    checkVal("abort.busy", 32'(Busy), 32'd0);
    checkVal("abort.tap", 32'(TapValue), 32'd0);
    checkVal("abort.flags", {30'd0, Done, Fail}, 32'd0);
    checkVal("abort.ew", 32'(EyeWidth), 32'd0);
    checkVal("abort.strobes",
      {30'd0, dqIf.DlyReset, dqIf.DlyInc}, 32'd0);
    Reset_n = 1'b1;
    runCal("rerun", 10, 30, 0, 0, 0, 1, 20, 21, 51);

`ifdef DQ_CAL_SWAP_DETECT_EN
    runCal("swap", 8, 16, 1, 0, 0, 1, 12, 9, 29);
`else
    runCal("inv", 8, 16, 1, 0, 0, 0, 0, 0, 63);
`endif

    checkVal("excl.strobes", 32'(bothCnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
